// File: rtl/note_roll_pkg.sv
// Shared constants for the scrolling note-roll display: default geometry,
// palette and the octave-to-colour mapping.
package note_roll_pkg;

  localparam int DEF_NUM_CH        = 7;
  localparam int DEF_LANE_X0       = 112;
  localparam int DEF_LANE_PITCH    = 64;
  localparam int DEF_LANE_W        = 32;
  localparam int DEF_Y_TOP         = 0;
  localparam int DEF_DEPTH         = 384;
  localparam int DEF_SCROLL_PERIOD = 100000;

  // Wide enough for the largest legal scroll period (2^20 -> max count 2^20-1).
  localparam int CNT_W = 20;

  localparam logic [23:0] COL_WHITE = 24'hFFFFFF;
  localparam logic [23:0] COL_OCT0  = 24'h000000;
  localparam logic [23:0] COL_OCT1  = 24'h0000FF;
  localparam logic [23:0] COL_OCT2  = 24'hFF0000;
  localparam logic [23:0] COL_OCT3  = 24'h00A000;

  typedef enum logic [1:0] {
    OCT_0 = 2'd0,
    OCT_1 = 2'd1,
    OCT_2 = 2'd2,
    OCT_3 = 2'd3
  } octave_e;

  function automatic logic [23:0] octave_colour(input logic [1:0] oct);
    logic [23:0] col;
    case (octave_e'(oct))
      OCT_0:   col = COL_OCT0;
      OCT_1:   col = COL_OCT1;
      OCT_2:   col = COL_OCT2;
      OCT_3:   col = COL_OCT3;
      default: col = COL_WHITE;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/roll_lane.sv
// One lane of key-held history: a DEPTH-bit shift register that scrolls toward
// row 0 on each tick, loads the live key level at the bottom row, and exposes one row.
module roll_lane
  import note_roll_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          vga_clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          clear,
  input  logic          din,
  input  logic [IW-1:0] rd_idx,
  output logic          rd_bit
);

  logic [DEPTH-1:0] hist_q;
  logic [DEPTH-1:0] hist_d;

  // Next history: clear beats tick so a wipe never carries a half-shifted row.
  always_comb begin
    hist_d = hist_q;
    if (clear) begin
      hist_d = '0;
    end else if (tick) begin
      hist_d = {din, hist_q[DEPTH-1:1]};
    end else begin
      hist_d = hist_q;
    end
  end

  // History register
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign rd_bit = hist_q[rd_idx];

endmodule

// File: rtl/note_roll_vga.sv
// Piano-roll style VGA overlay: per-lane key history scrolls upward on a
// programmable tick and is painted as coloured blocks, one pixel per cycle.
module note_roll_vga
  import note_roll_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int LANE_X0       = DEF_LANE_X0,
  parameter int LANE_PITCH    = DEF_LANE_PITCH,
  parameter int LANE_W        = DEF_LANE_W,
  parameter int Y_TOP         = DEF_Y_TOP,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int SCROLL_PERIOD = DEF_SCROLL_PERIOD
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [NUM_CH-1:0] note,
  input  logic [1:0]        shift,
  input  logic              freeze,
  input  logic              clear,
  output logic [23:0]       pos_data
);

  localparam int               IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCROLL_PERIOD - 1);
  localparam logic [31:0]      ROW_LO   = 32'(Y_TOP);
  localparam logic [31:0]      ROW_HI   = 32'(Y_TOP + DEPTH);

  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [DEPTH-1:0][1:0] oct_q;
  logic [DEPTH-1:0][1:0] oct_d;
  logic [23:0]           pos_data_q;
  logic [23:0]           pos_data_d;

  logic                  tick_s;
  logic [31:0]           x_w_s;
  logic [31:0]           y_w_s;
  logic                  in_rows_s;
  logic [IW-1:0]         row_idx_s;
  logic [NUM_CH-1:0]     in_x_s;
  logic [NUM_CH-1:0]     lane_bit_s;

  assign tick_s = rst_n & ~freeze & (cnt_q == CNT_LAST);

  // Pixel compares run at 32 bits so lane/row bounds past 1023 never wrap.
  assign x_w_s     = {22'd0, pos_x};
  assign y_w_s     = {22'd0, pos_y};
  assign in_rows_s = ((y_w_s + 32'd1) > ROW_LO) && (y_w_s < ROW_HI);
  assign row_idx_s = IW'(pos_y - 10'(Y_TOP));

  // Scroll-tick counter: frozen counts hold, clear restarts the period.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (freeze) begin
      cnt_d = cnt_q;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Shared octave history, scrolling in lock-step with the lanes.
  always_comb begin
    oct_d = oct_q;
    if (clear) begin
      oct_d = '0;
    end else if (tick_s) begin
      oct_d = {shift, oct_q[DEPTH-1:1]};
    end else begin
      oct_d = oct_q;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    localparam logic [31:0] X_LO = 32'(LANE_X0 + k * LANE_PITCH);
    localparam logic [31:0] X_HI = 32'(LANE_X0 + k * LANE_PITCH + LANE_W);

    assign in_x_s[k] = ((x_w_s + 32'd1) > X_LO) && (x_w_s < X_HI);

    roll_lane #(
      .DEPTH (DEPTH),
      .IW    (IW)
    ) u_lane (
      .vga_clk (vga_clk),
      .rst_n   (rst_n),
      .tick    (tick_s),
      .clear   (clear),
      .din     (note[k]),
      .rd_idx  (row_idx_s),
      .rd_bit  (lane_bit_s[k])
    );
  end

  // Lanes never overlap, so at most one lane bit can be selected here.
  always_comb begin
    pos_data_d = COL_WHITE;
    if (in_rows_s && ((in_x_s & lane_bit_s) != '0)) begin
      pos_data_d = octave_colour(oct_q[row_idx_s]);
    end else begin
      pos_data_d = COL_WHITE;
    end
  end

  // State and output registers
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      oct_q      <= '0;
      pos_data_q <= COL_WHITE;
    end else begin
      cnt_q      <= cnt_d;
      oct_q      <= oct_d;
      pos_data_q <= pos_data_d;
    end
  end

  assign pos_data = pos_data_q;

endmodule

// File: tb/tb_note_roll_vga.sv
// Directed bench for note_roll_vga (SCROLL_PERIOD=4, DEPTH=16): table of pixel
// reads per scenario, hand-written tick/freeze/clear/reset sequences, and a model-checked sweep.
module tb_note_roll_vga;

  logic       vga_clk = 1'b0;
  logic       rst_n;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [6:0] note;
  logic [1:0] shift;
  logic       freeze;
  logic       clear;
  logic [23:0] pos_data;

  int n_cmp = 0;
  int n_bad = 0;

  note_roll_vga #(
    .SCROLL_PERIOD (4),
    .DEPTH         (16),
    .Y_TOP         (0)
  ) dut (
    .vga_clk  (vga_clk),
    .rst_n    (rst_n),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .note     (note),
    .shift    (shift),
    .freeze   (freeze),
    .clear    (clear),
    .pos_data (pos_data)
  );

  always #5 vga_clk = ~vga_clk;

  // Independent behavioural reference used by the sweep.
  logic [15:0] m_hist [7];
  logic [1:0]  m_oct  [16];
  int          m_cnt;
  logic [23:0] m_pix;

  function automatic logic [23:0] ref_pix(input logic [9:0] x, input logic [9:0] y);
    logic [23:0] c;
    c = 24'hFFFFFF;
    for (int k = 0; k < 7; k++) begin
      int lo;
      lo = 112 + 64 * k;
      if (int'(x) >= lo && int'(x) < lo + 32 && int'(y) < 16) begin
        if (m_hist[k][y[3:0]]) begin
          case (m_oct[y[3:0]])
            2'd0:    c = 24'h000000;
            2'd1:    c = 24'h0000FF;
            2'd2:    c = 24'hFF0000;
            default: c = 24'h00A000;
          endcase
        end
      end
    end
    return c;
  endfunction

  always @(posedge vga_clk) begin
    if (!rst_n) begin
      m_cnt <= 0;
      m_pix <= 24'hFFFFFF;
      for (int k = 0; k < 7; k++) m_hist[k] <= 16'd0;
      for (int r = 0; r < 16; r++) m_oct[r] <= 2'd0;
    end else begin
      m_pix <= ref_pix(pos_x, pos_y);
      if (clear) begin
        m_cnt <= 0;
        for (int k = 0; k < 7; k++) m_hist[k] <= 16'd0;
        for (int r = 0; r < 16; r++) m_oct[r] <= 2'd0;
      end else if (!freeze) begin
        if (m_cnt == 3) begin
          m_cnt <= 0;
          for (int k = 0; k < 7; k++) m_hist[k] <= {note[k], m_hist[k][15:1]};
          for (int r = 0; r < 15; r++) m_oct[r] <= m_oct[r+1];
          m_oct[15] <= shift;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  typedef struct {
    int          ph;
    int          x;
    int          y;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic cyc();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask

  task automatic check(input string nm, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: pos_data=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic rd(input string nm, input int x, input int y, input logic [23:0] exp);
    freeze = 1'b1;
    pos_x  = 10'(x);
    pos_y  = 10'(y);
    cyc();
    check($sformatf("%s(%0d,%0d)", nm, x, y), pos_data, exp);
  endtask

  task automatic run_phase(input int ph);
    foreach (vecs[i]) begin
      if (vecs[i].ph == ph) rd($sformatf("ph%0d", ph), vecs[i].x, vecs[i].y, vecs[i].exp);
    end
  endtask

  task automatic do_clear();
    freeze = 1'b0;
    clear  = 1'b1;
    cyc();
    clear  = 1'b0;
  endtask

  // From a counter value of 0, run exactly one scroll period with the given inputs.
  task automatic tick_with(input logic [6:0] n, input logic [1:0] s);
    note   = n;
    shift  = s;
    freeze = 1'b0;
    cycles(4);
    note   = 7'd0;
    shift  = 2'd0;
    freeze = 1'b1;
  endtask

  int xs[14] = '{111, 112, 143, 144, 175, 176, 240, 304, 335, 336, 496, 527, 528, 600};

  initial begin
    vecs.push_back('{1, 112, 15, 24'h0000FF});
    vecs.push_back('{1, 143, 15, 24'h0000FF});
    vecs.push_back('{1, 144, 15, 24'hFFFFFF});
    vecs.push_back('{1, 111, 15, 24'hFFFFFF});
    vecs.push_back('{1, 112, 14, 24'hFFFFFF});
    vecs.push_back('{2, 112, 12, 24'h0000FF});
    vecs.push_back('{2, 112, 15, 24'hFFFFFF});
    vecs.push_back('{2, 112, 13, 24'hFFFFFF});
    vecs.push_back('{2, 112, 11, 24'hFFFFFF});
    vecs.push_back('{3, 496, 15, 24'hFF0000});
    vecs.push_back('{3, 527, 15, 24'hFF0000});
    vecs.push_back('{3, 528, 15, 24'hFFFFFF});
    vecs.push_back('{3, 100, 15, 24'hFFFFFF});
    vecs.push_back('{3, 112, 15, 24'hFFFFFF});
    vecs.push_back('{4, 304, 14, 24'h00A000});
    vecs.push_back('{4, 304, 15, 24'h000000});
    vecs.push_back('{4, 112, 15, 24'h000000});
    vecs.push_back('{4, 112, 14, 24'hFFFFFF});
    vecs.push_back('{4, 335, 15, 24'h000000});
    vecs.push_back('{4, 336, 15, 24'hFFFFFF});

    rst_n  = 1'b0;
    pos_x  = 10'd112;
    pos_y  = 10'd15;
    note   = 7'd0;
    shift  = 2'd0;
    freeze = 1'b0;
    clear  = 1'b0;
    cycles(2);
    check("reset_out", pos_data, 24'hFFFFFF);
    rst_n = 1'b1;

    // Single block in lane 0, octave 1, then three more ticks.
    do_clear();
    tick_with(7'b0000001, 2'd1);
    run_phase(1);
    freeze = 1'b0;
    cycles(12);
    run_phase(2);

    // Lane 6, octave 2.
    do_clear();
    tick_with(7'b1000000, 2'd2);
    run_phase(3);

    // Two ticks with different octaves stack in lane 3.
    do_clear();
    tick_with(7'b0001000, 2'd3);
    tick_with(7'b0001001, 2'd0);
    run_phase(4);

    // Freeze mid-count: position held, tick after the remaining two counts.
    do_clear();
    tick_with(7'b0000001, 2'd1);
    freeze = 1'b0;
    cycles(2);
    freeze = 1'b1;
    pos_x  = 10'd112;
    pos_y  = 10'd15;
    cycles(10);
    check("frz_hold(112,15)", pos_data, 24'h0000FF);
    rd("frz_hold", 112, 14, 24'hFFFFFF);
    freeze = 1'b0;
    cyc();
    rd("frz_notick", 112, 15, 24'h0000FF);
    freeze = 1'b0;
    cyc();
    rd("frz_tick", 112, 14, 24'h0000FF);
    rd("frz_tick", 112, 15, 24'hFFFFFF);

    // Clear coincident with a tick, then the next tick exactly 4 cycles later.
    do_clear();
    note   = 7'h7F;
    shift  = 2'd1;
    freeze = 1'b0;
    cycles(3);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    cycles(3);
    rd("clr_win", 112, 15, 24'hFFFFFF);
    rd("clr_win", 304, 15, 24'hFFFFFF);
    rd("clr_win", 496, 15, 24'hFFFFFF);
    freeze = 1'b0;
    cyc();
    note = 7'd0;
    rd("clr_next", 112, 15, 24'h0000FF);
    rd("clr_next", 496, 15, 24'h0000FF);
    rd("clr_next", 112, 14, 24'hFFFFFF);

    // One-cycle reset with populated history.
    pos_x = 10'd112;
    pos_y = 10'd15;
    rst_n = 1'b0;
    cyc();
    check("rst_pulse_out", pos_data, 24'hFFFFFF);
    rst_n = 1'b1;
    rd("rst_empty", 112, 15, 24'hFFFFFF);
    rd("rst_empty", 496, 15, 24'hFFFFFF);

    // Sweep against the reference model, scrolling as it goes.
    do_clear();
    check("sweep_clr", pos_data, m_pix);
    for (int i = 0; i < 64; i++) begin
      note   = 7'($urandom_range(0, 127));
      shift  = 2'($urandom_range(0, 3));
      freeze = 1'b0;
      pos_x  = 10'($urandom_range(100, 560));
      pos_y  = 10'($urandom_range(0, 20));
      cyc();
      check("sweep_fill", pos_data, m_pix);
    end
    foreach (xs[i]) begin
      for (int y = 0; y < 19; y++) begin
        note   = 7'($urandom_range(0, 127));
        shift  = 2'($urandom_range(0, 3));
        freeze = ($urandom_range(0, 7) == 0);
        pos_x  = 10'(xs[i]);
        pos_y  = (y == 18) ? 10'd1023 : 10'(y);
        cyc();
        check($sformatf("sweep(%0d,%0d)", xs[i], pos_y), pos_data, m_pix);
      end
    end
    freeze = 1'b1;
    rd("sweep_row16", 112, 16, 24'hFFFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/note_roll_vga.md
NOTE_ROLL_VGA -- requirements
Module: note_roll_vga

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 7, meaning lane count; lane k is driven by note[k], lane 0 is leftmost.
REQ-002 The block SHALL have parameter LANE_X0, default 112, meaning the x of lane 0's left edge.
REQ-003 The block SHALL have parameter LANE_PITCH, default 64, meaning the x distance between adjacent lane left edges.
REQ-004 The block SHALL have parameter LANE_W, default 32, meaning lane width in pixels; LANE_W <= LANE_PITCH.
REQ-005 The block SHALL have parameter Y_TOP, default 0, meaning the first displayed row.
REQ-006 The block SHALL have parameter DEPTH, default 384, meaning history rows per lane; Y_TOP+DEPTH <= 1024.
REQ-007 The block SHALL have parameter SCROLL_PERIOD, default 100000, meaning vga_clk cycles per scroll tick; valid range 2..2^20.
REQ-008 Port vga_clk, input, width 1: the single clock.
REQ-009 Port rst_n, input, width 1: reset, synchronous, active-low.
REQ-010 Port pos_x, input, width 10: current pixel column.
REQ-011 Port pos_y, input, width 10: current pixel row.
REQ-012 Port note, input, width NUM_CH: per-lane key-held level.
REQ-013 Port shift, input, width 2: octave, sampled together with note.
REQ-014 Port freeze, input, width 1: level-sensitive scroll pause.
REQ-015 Port clear, input, width 1: one-cycle pulse that wipes the history.
REQ-016 Port pos_data, output, width 24: registered RGB888 pixel.

Function
REQ-017 The tick counter SHALL count 0..SCROLL_PERIOD-1 and wrap; tick SHALL be high for one cycle when the count equals SCROLL_PERIOD-1 and freeze=0.
REQ-018 While freeze=1 the counter SHALL hold its value and no tick SHALL occur.
REQ-019 On tick, every lane history SHALL shift one row toward Y_TOP, row DEPTH-1 (bottom) SHALL load note[k], and the oldest row SHALL be discarded.
REQ-020 On tick, a shared per-row 2-bit octave history SHALL shift identically, with the bottom row loading shift.
REQ-021 On clear, all lane and octave history bits SHALL go to 0 on the next edge, and the counter SHALL restart at 0.
REQ-022 If clear and tick occur in the same cycle, clear SHALL win and no shift SHALL occur.
REQ-023 A pixel SHALL be in lane k iff LANE_X0+k*LANE_PITCH <= pos_x < LANE_X0+k*LANE_PITCH+LANE_W and Y_TOP <= pos_y < Y_TOP+DEPTH; the comparisons SHALL be unsigned and performed at 11+ bits with no wrap.
REQ-024 Within a lane, the row index SHALL be r = pos_y - Y_TOP.
REQ-025 If history bit r of lane k is 1, the colour SHALL be selected by octave[r]: 0 -> 24'h000000, 1 -> 24'h0000FF, 2 -> 24'hFF0000, 3 -> 24'h00A000.
REQ-026 If the pixel is in a lane but history bit r is 0, the colour SHALL be 24'hFFFFFF.
REQ-027 If the pixel is outside every lane, the colour SHALL be 24'hFFFFFF.
REQ-028 pos_data SHALL have a latency of exactly 1 cycle from pos_x/pos_y.
REQ-029 pos_data SHALL reflect history as it stands at the same clock edge; a tick and a pixel read in the same cycle SHALL see the pre-shift history.

Reset
REQ-030 While rst_n=0 at a clock edge, the counter, all lane and octave history, and the tick SHALL be 0, and pos_data SHALL be 24'hFFFFFF.
REQ-031 Reset asserted mid-scroll SHALL discard history with no partial shift.

Structure
REQ-032 Colour constants, default geometry and the octave-to-colour function SHALL reside in package note_roll_pkg.
REQ-033 One sub-module, roll_lane, SHALL hold a single DEPTH-bit shift history with tick/clear and a row-read port, and SHALL be instantiated NUM_CH times; the octave history and tick counter SHALL stay in the top.

Verification (SCROLL_PERIOD=4, DEPTH=16, Y_TOP=0, defaults otherwise)
REQ-034 Hold note=7'b0000001 and shift=1 for 1 tick, then 0 -> (112,15) reads 24'h0000FF; after 3 more ticks it reads at (112,12) and (112,15) reads 24'hFFFFFF.
REQ-035 Hold note[6]=1 and shift=2 for 1 tick -> (496,15) reads 24'hFF0000; (528,15) (gap) and (100,15) read 24'hFFFFFF.
REQ-036 Freeze for 10 cycles mid-count -> block position unchanged; the next tick arrives exactly after the remaining count once freeze drops.
REQ-037 Pulse clear coincident with a tick with note all-1 -> all pixels 24'hFFFFFF, and the next tick occurs 4 cycles later.
REQ-038 Pulse rst_n=0 for 1 cycle with history populated -> pos_data is 24'hFFFFFF and all lanes are empty afterward.
REQ-039 Sweep pos_x/pos_y every cycle -> pos_data matches a reference model delayed by 1 cycle, including pos_y=16 (out of rows) reading white.
